aes_inv_cipher_iter: RTL

//  Iterative AES inverse cipher: one round per clk, for AES-128/192/256 selected by NK.

---
 rtl/aes_pkg.sv | 57 +++++
 rtl/aes_inv_round.sv | 48 ++++
 rtl/aes_inv_cipher_iter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, FSM encoding, inverse S-box and GF(2^8) helpers
package aes_pkg;

  typedef logic [0:127] aes_block_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aes_fsm_e;

  // Byte x of the inverse S-box lives at bits [8*x +: 8].
  localparam logic [0:2047] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic int nr_of(input int nk);
    return nk + 6;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiplier operands in InvMixColumns never exceed 4'he, so a nibble suffices.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX[8*int'(x) +: 8];
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - one combinational AES inverse round, final-round variant skips InvMixColumns
module aes_inv_round
  import aes_pkg::*;
(
  input  aes_block_t state_i,
  input  aes_block_t rk_i,
  input  logic       is_final_i,
  output aes_block_t next_o
);

  aes_block_t sr;
  aes_block_t sb;
  aes_block_t ark;
  aes_block_t mc;
  logic [7:0] a0, a1, a2, a3;

  // Byte index is row + 4*column; row r rotates right by r columns.
  always_comb begin
    sr = '0;
    sb = '0;
    mc = '0;
    a0 = '0;
    a1 = '0;
    a2 = '0;
    a3 = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[8*(r+4*c) +: 8] = state_i[8*(r+4*((c-r+4)%4)) +: 8];
      end
    end
    for (int i = 0; i < 16; i++) begin
      sb[8*i +: 8] = inv_sbox(sr[8*i +: 8]);
    end
    ark = sb ^ rk_i;
    for (int c = 0; c < 4; c++) begin
      a0 = ark[32*c      +: 8];
      a1 = ark[32*c + 8  +: 8];
      a2 = ark[32*c + 16 +: 8];
      a3 = ark[32*c + 24 +: 8];
      mc[32*c      +: 8] = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
      mc[32*c + 8  +: 8] = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
      mc[32*c + 16 +: 8] = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
      mc[32*c + 24 +: 8] = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
    end
    next_o = is_final_i ? ark : mc;
  end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// rtl/aes_inv_cipher_iter.sv - iterative AES-128/192/256 inverse cipher, one round per clock
// Define AES_INBUF_EN to add a one-entry input skid buffer for gap-free back-to-back blocks.
module aes_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int NK = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [0:127]          in_data,
  input  logic [0:128*(NK+7)-1] words,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [0:127]          out_data,
  output logic                  busy
);

  localparam int NR = nr_of(NK);

  if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
    $error("aes_inv_cipher_iter: NK must be 4, 6 or 8");
  end

  aes_fsm_e   fsm_q;
  aes_block_t blk_q;
  aes_block_t blk_d;
  aes_block_t start_src;
  aes_block_t rk_rnd;
  aes_block_t rk_top;
  logic [3:0] rnd_q;
  logic       out_valid_q;
  logic       busy_q;
  logic       take;
  logic       start_vld;
  logic       start;

  assign rk_top = words[128*NR +: 128];
  assign rk_rnd = words[128*int'(rnd_q) +: 128];
  assign take   = in_valid && in_ready;

  aes_inv_round u_round (
    .state_i    (blk_q),
    .rk_i       (rk_rnd),
    .is_final_i (rnd_q == 4'd0),
    .next_o     (blk_d)
  );

`ifdef AES_INBUF_EN
  aes_block_t buf_q;
  logic       buf_valid_q;
  logic       buf_load;

  assign in_ready  = !reset && !buf_valid_q;
  assign start_vld = buf_valid_q || take;
  assign start_src = buf_valid_q ? buf_q : in_data;
  // A block arriving on the DONE handshake edge bypasses the buffer.
  assign buf_load  = take && (fsm_q == RUN || (fsm_q == DONE && !out_ready));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_valid_q <= 1'b0;
      buf_q       <= '0;
    end else if (buf_load) begin
      buf_valid_q <= 1'b1;
      buf_q       <= in_data;
    end else if (fsm_q == DONE && out_ready) begin
      buf_valid_q <= 1'b0;
    end
  end
`else
  assign in_ready  = !reset && (fsm_q == IDLE || (fsm_q == DONE && out_ready));
  assign start_vld = take;
  assign start_src = in_data;
`endif

  assign start = start_vld && (fsm_q == IDLE || (fsm_q == DONE && out_ready));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q       <= IDLE;
      blk_q       <= '0;
      rnd_q       <= 4'd0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (start) begin
      fsm_q       <= RUN;
      blk_q       <= start_src ^ rk_top;
      rnd_q       <= 4'(NR - 1);
      out_valid_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      case (fsm_q)
        IDLE: ;
        RUN: begin
          blk_q <= blk_d;
          if (rnd_q == 4'd0) begin
            fsm_q       <= DONE;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            rnd_q <= rnd_q - 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            fsm_q       <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = blk_q;
  assign busy      = busy_q;

endmodule
